// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes used by both the control unit and the datapath ALU,
// control-unit state encoding and the datapath strobe bundle.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 5;

  typedef logic [OPCODE_W-1:0] opcode_t;

  // ALU set occupies 00000-01010; MUL/DIV and HALT are decoded separately.
  localparam opcode_t OP_ADD  = 5'b00000;
  localparam opcode_t OP_SUB  = 5'b00001;
  localparam opcode_t OP_SHR  = 5'b00010;
  localparam opcode_t OP_SHRA = 5'b00011;
  localparam opcode_t OP_SHL  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_ROR  = 5'b00111;
  localparam opcode_t OP_ROL  = 5'b01000;
  localparam opcode_t OP_NEG  = 5'b01001;
  localparam opcode_t OP_NOT  = 5'b01010;
  localparam opcode_t OP_MUL  = 5'b01111;
  localparam opcode_t OP_DIV  = 5'b10000;
  localparam opcode_t OP_HALT = 5'b11100;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic zhigh_out;
    logic mdr_out;
    logic mar_in;
    logic z_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic inc_pc;
    logic read;
    logic hi_in;
    logic lo_in;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
  } ctrl_t;

  function automatic logic is_alu_op(input opcode_t op);
    return (op <= OP_NOT);
  endfunction

  function automatic logic is_muldiv_op(input opcode_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch (T0-T2), execute (T3-T6) and HALT,
// plus a wrapping count of fetched instructions.
module control_unit
  import cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        HIin,
  output logic        LOin,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  operation,
  output logic        Run,
  output logic [15:0] instr_count
);

  state_e      state_q, state_d;
  opcode_t     op_q, op_d;
  logic        muldiv_q, muldiv_d;
  logic [15:0] instr_count_q;
  opcode_t     opcode;
  logic        ir_unused;
  ctrl_t       ctrl;

  assign opcode    = IR[31:27];
  assign ir_unused = ^IR[26:0];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_RST;
      op_q          <= '0;
      muldiv_q      <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      muldiv_q <= muldiv_d;
      if (state_q == ST_T2) begin
        instr_count_q <= instr_count_q + 16'd1;
      end
    end
  end

  // The opcode class is captured leaving T2 so T4-T6 decode from registers only.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    muldiv_d = muldiv_q;
    case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0:  state_d = ST_T1;
      ST_T1:  state_d = ST_T2;
      ST_T2: begin
        if (is_alu_op(opcode) || is_muldiv_op(opcode)) begin
          state_d  = ST_T3;
          op_d     = opcode;
          muldiv_d = is_muldiv_op(opcode);
        end else if (opcode == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = Stop ? ST_HALT : ST_T0;
        end
      end
      ST_T3: state_d = ST_T4;
      ST_T4: state_d = ST_T5;
      ST_T5: begin
        if (muldiv_q) begin
          state_d = ST_T6;
        end else begin
          state_d = Stop ? ST_HALT : ST_T0;
        end
      end
      ST_T6:   state_d = Stop ? ST_HALT : ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  always_comb begin
    ctrl      = '0;
    operation = '0;
    Run       = 1'b0;
    case (state_q)
      ST_T0: begin
        Run         = 1'b1;
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
      end
      ST_T1: begin
        Run           = 1'b1;
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
      end
      ST_T2: begin
        Run          = 1'b1;
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      ST_T3: begin
        Run        = 1'b1;
        ctrl.grb   = 1'b1;
        ctrl.r_out = 1'b1;
        ctrl.y_in  = 1'b1;
      end
      ST_T4: begin
        Run        = 1'b1;
        ctrl.grc   = 1'b1;
        ctrl.r_out = 1'b1;
        ctrl.z_in  = 1'b1;
        operation  = op_q;
      end
      ST_T5: begin
        Run           = 1'b1;
        ctrl.zlow_out = 1'b1;
        if (muldiv_q) begin
          ctrl.lo_in = 1'b1;
        end else begin
          ctrl.gra  = 1'b1;
          ctrl.r_in = 1'b1;
        end
      end
      ST_T6: begin
        Run            = 1'b1;
        ctrl.zhigh_out = 1'b1;
        ctrl.hi_in     = 1'b1;
      end
      default: begin
        ctrl      = '0;
        operation = '0;
        Run       = 1'b0;
      end
    endcase
  end

  assign PCout       = ctrl.pc_out;
  assign Zlowout     = ctrl.zlow_out;
  assign ZHighout    = ctrl.zhigh_out;
  assign MDRout      = ctrl.mdr_out;
  assign MARin       = ctrl.mar_in;
  assign Zin         = ctrl.z_in;
  assign PCin        = ctrl.pc_in;
  assign MDRin       = ctrl.mdr_in;
  assign IRin        = ctrl.ir_in;
  assign Yin         = ctrl.y_in;
  assign IncPC       = ctrl.inc_pc;
  assign Read        = ctrl.read;
  assign HIin        = ctrl.hi_in;
  assign LOin        = ctrl.lo_in;
  assign GRA         = ctrl.gra;
  assign GRB         = ctrl.grb;
  assign GRC         = ctrl.grc;
  assign Rin         = ctrl.r_in;
  assign Rout        = ctrl.r_out;
  assign BAout       = ctrl.ba_out;
  assign instr_count = instr_count_q;

endmodule
